// File: rtl/stopwatch_core.sv
// Stopwatch timebase: debounced start/stop and clear buttons, run/pause FSM, SS.cc BCD counter.
// Define STOPWATCH_LAP_EN to add a lap button that freezes the displayed value.
module stopwatch_core #(
    parameter int unsigned TICK_DIV        = 1000000,
    parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic        btn_lap,
`endif
    output logic [15:0] digits,
    output logic        running,
    output logic        wrapped
);

`ifdef STOPWATCH_LAP_EN
    localparam int unsigned NumBtn = 3;
`else
    localparam int unsigned NumBtn = 2;
`endif
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PreW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    logic [NumBtn-1:0] btn_raw;
    logic [NumBtn-1:0] sync1_q, sync2_q, level_q, level_prev_q, press_q;
    logic [CntW-1:0]   db_cnt_q [NumBtn];

    state_e            state_q;
    logic [PreW-1:0]   presc_q;
    logic [15:0]       count_q, count_inc, count_next;
    logic              roll, tick;
    logic              press_ss, press_clr;

`ifdef STOPWATCH_LAP_EN
    logic              press_lap;
    logic              lap_hold_q;
    logic [15:0]       lap_q;
    assign btn_raw   = {btn_lap, btn_clear, btn_start_stop};
    assign press_lap = press_q[2];
    assign digits    = lap_hold_q ? lap_q : count_q;
`else
    assign btn_raw   = {btn_clear, btn_start_stop};
    assign digits    = count_q;
`endif
    assign press_ss  = press_q[0];
    assign press_clr = press_q[1];

    // Level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            press_q      <= '0;
            for (int i = 0; i < NumBtn; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
            for (int i = 0; i < NumBtn; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    level_q[i]  <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign tick = (state_q == StRun) && (presc_q == PreW'(TICK_DIV - 1));

    always_comb begin
        count_inc = count_q;
        roll      = 1'b0;
        if (count_q[3:0] != 4'd9) begin
            count_inc[3:0] = count_q[3:0] + 4'd1;
        end else begin
            count_inc[3:0] = 4'd0;
            if (count_q[7:4] != 4'd9) begin
                count_inc[7:4] = count_q[7:4] + 4'd1;
            end else begin
                count_inc[7:4] = 4'd0;
                if (count_q[11:8] != 4'd9) begin
                    count_inc[11:8] = count_q[11:8] + 4'd1;
                end else begin
                    count_inc[11:8] = 4'd0;
                    if (count_q[15:12] != 4'd5) begin
                        count_inc[15:12] = count_q[15:12] + 4'd1;
                    end else begin
                        count_inc[15:12] = 4'd0;
                        roll             = 1'b1;
                    end
                end
            end
        end
        count_next = tick ? count_inc : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            count_q    <= '0;
            wrapped    <= 1'b0;
            running    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_hold_q <= 1'b0;
            lap_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (press_ss || press_clr) wrapped <= 1'b0;
                    if (press_ss) begin
                        state_q <= StRun;
                        presc_q <= '0;
                        running <= 1'b1;
                    end
                end
                StRun: begin
                    // A tick landing on the pause press still counts.
                    presc_q <= tick ? '0 : presc_q + 1'b1;
                    count_q <= count_next;
                    if (tick && roll) wrapped <= 1'b1;
                    if (press_ss) begin
                        state_q <= StPause;
                        running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
                        lap_hold_q <= 1'b0;
                    end else if (press_lap) begin
                        lap_hold_q <= ~lap_hold_q;
                        if (!lap_hold_q) lap_q <= count_next;
`endif
                    end
                end
                StPause: begin
                    if (press_clr) begin
                        state_q <= StIdle;
                        count_q <= '0;
                        wrapped <= 1'b0;
                        presc_q <= '0;
                    end else if (press_ss) begin
                        state_q <= StRun;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: an integer-centisecond reference model queues the expected
// outputs every clock and a negedge monitor pops and compares them against the DUT.
module tb_stopwatch_core;

    localparam int unsigned TD = 4;
    localparam int unsigned DC = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_ss = 1'b0;
    logic        btn_clr = 1'b0;
`ifdef STOPWATCH_LAP_EN
    logic        btn_lap = 1'b0;
`endif
    logic [15:0] digits;
    logic        running;
    logic        wrapped;

    int n_cmp = 0;
    int n_bad = 0;

    stopwatch_core #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (btn_ss),
        .btn_clear      (btn_clr),
`ifdef STOPWATCH_LAP_EN
        .btn_lap        (btn_lap),
`endif
        .digits         (digits),
        .running        (running),
        .wrapped        (wrapped)
    );

    always #5 clk = ~clk;

    // Reference model: count kept as plain centiseconds, phase as run cycles within a tick.
    int  m_state;      // 0 idle, 1 run, 2 pause
    int  m_count;
    int  m_phase;
    bit  m_wrapped;
    bit  m_lap_hold;
    int  m_lap;
    bit  raw1 [3];     // raw sample seen one edge ago
    bit  raw2 [3];     // raw sample seen two edges ago
    int  run_len [3];
    bit  lvl [3];
    bit  rise1 [3];
    bit  rise2 [3];
    logic [17:0] exp_q [$];

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    always @(posedge clk) begin
        bit raw [3];
        bit pr [3];
        bit s;
        raw[0] = btn_ss;
        raw[1] = btn_clr;
`ifdef STOPWATCH_LAP_EN
        raw[2] = btn_lap;
`else
        raw[2] = 1'b0;
`endif
        if (rst) begin
            m_state = 0; m_count = 0; m_phase = 0; m_wrapped = 0; m_lap_hold = 0; m_lap = 0;
            for (int i = 0; i < 3; i++) begin
                raw1[i] = 0; raw2[i] = 0; run_len[i] = 0; lvl[i] = 0; rise1[i] = 0; rise2[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                pr[i]    = rise2[i];
                rise2[i] = rise1[i];
                s        = raw2[i];
                raw2[i]  = raw1[i];
                raw1[i]  = raw[i];
                rise1[i] = 0;
                if (s != lvl[i]) begin
                    run_len[i]++;
                    if (run_len[i] == DC) begin
                        lvl[i]     = s;
                        run_len[i] = 0;
                        rise1[i]   = s;
                    end
                end else begin
                    run_len[i] = 0;
                end
            end
            case (m_state)
                0: begin
                    if (pr[0] || pr[1]) m_wrapped = 0;
                    if (pr[0]) begin m_state = 1; m_phase = 0; end
                end
                1: begin
                    m_phase++;
                    if (m_phase == TD) begin
                        m_phase = 0;
                        m_count = (m_count + 1) % 6000;
                        if (m_count == 0) m_wrapped = 1;
                    end
                    if (pr[0]) begin
                        m_state = 2;
                        m_lap_hold = 0;
                    end else if (pr[2]) begin
                        if (!m_lap_hold) m_lap = m_count;
                        m_lap_hold = !m_lap_hold;
                    end
                end
                default: begin
                    if (pr[1]) begin
                        m_state = 0; m_count = 0; m_wrapped = 0; m_phase = 0;
                    end else if (pr[0]) begin
                        m_state = 1;
                    end
                end
            endcase
        end
        exp_q.push_back({m_lap_hold ? to_bcd(m_lap) : to_bcd(m_count), m_state == 1, m_wrapped});
    end

    always @(negedge clk) begin
        logic [17:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({digits, running, wrapped} !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t got digits=%h running=%b wrapped=%b, expected digits=%h running=%b wrapped=%b",
                         $time, digits, running, wrapped, e[17:2], e[1], e[0]);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input bit ss, input bit clr, input bit lap, input int hold);
        @(negedge clk);
        btn_ss  = ss;
        btn_clr = clr;
`ifdef STOPWATCH_LAP_EN
        btn_lap = lap;
`endif
        cycles(hold);
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
`ifdef STOPWATCH_LAP_EN
        btn_lap = 1'b0;
`endif
        cycles(12);
    endtask

    task automatic wait_count(input int target);
        int k;
        k = 0;
        while (m_count != target && k < 30000) begin
            @(negedge clk);
            k++;
        end
        if (m_count != target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_count timeout: count %0d, wanted %0d", m_count, target);
        end
    endtask

    initial begin
        int r;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // Start, count through a few tenths, pause and clear
        push(1, 0, 0, 10);
        cycles(60);
        push(1, 0, 0, 8);
        push(0, 1, 0, 8);

        // Bouncing start button never reaches the debounce threshold
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            btn_ss = (i % 2 == 0);
        end
        btn_ss = 1'b0;
        cycles(20);

        // Run through the 59.99 -> 00.00 wrap, then pause and clear
        push(1, 0, 0, 8);
        cycles(24100);
        push(1, 0, 0, 8);
        push(0, 1, 0, 8);

        // Pause at a random phase of the prescaler and resume
        push(1, 0, 0, 6);
        cycles($urandom_range(0, 7));
        push(1, 0, 0, 5);
        cycles(50);
        push(1, 0, 0, 5);
        cycles(30);

        // Simultaneous clear + start_stop while paused, then clear alone while running
        push(1, 0, 0, 5);
        push(1, 1, 0, 6);
        push(1, 0, 0, 6);
        cycles(20);
        push(0, 1, 0, 6);
        cycles(20);

        // Reset in the middle of a run at 12.34
        wait_count(1234);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cycles(10);

        // Random button activity
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 10));
            if (r <= 4)       push(1, 0, 0, int'($urandom_range(1, 8)));
            else if (r <= 6)  push(0, 1, 0, int'($urandom_range(1, 8)));
            else if (r == 7)  push(1, 1, 0, int'($urandom_range(1, 8)));
            else if (r == 8)  push(0, 0, 1, int'($urandom_range(1, 8)));
            else begin
                for (int j = 0; j < 6; j++) begin
                    @(negedge clk);
                    btn_ss  = 1'($urandom_range(0, 1));
                    btn_clr = 1'($urandom_range(0, 1));
                end
                btn_ss  = 1'b0;
                btn_clr = 1'b0;
                cycles(12);
            end
            cycles(int'($urandom_range(0, 60)));
        end

`ifdef STOPWATCH_LAP_EN
        // Lap freeze and release while the live count keeps running
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push(1, 0, 0, 6);
        wait_count(12);
        push(0, 0, 1, 6);
        cycles(40);
        push(0, 0, 1, 6);
        cycles(20);
`endif

        cycles(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
